fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Shares the single write port of one fifo instance among NUM_REQ producers on the fifo input clock.
//  Round-robin grant per burst; a burst ends on req_last, MAX_BURST beats or HOLD_TIMEOUT idle cycles.
//  Sits directly in front of the fifo data_in/data_in_valid/data_in_full interface.
//  Combinational data mux; control (grant, counters, pointer) is registered.
// PARAMETERS
//  NUM_REQ       4    number of producers, 2..16
//  DATA_WIDTH    32   beat width, equals the fifo DATA_WIDTH
//  MAX_BURST     16   max beats per grant, 1..255
//  HOLD_TIMEOUT  8    consecutive granted cycles with req_valid low before forced release, 1..255
//  ID_W          clog2(NUM_REQ), derived localparam, never overridden
// PORTS
//  clock       in   1                   single clock (fifo clock_in domain)
//  rst         in   1                   synchronous reset, active-high
//  req_valid   in   NUM_REQ             per-producer beat valid
//  req_data    in   NUM_REQ*DATA_WIDTH  packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last    in   NUM_REQ             final beat of burst, qualified by req_valid
//  req_ready   out  NUM_REQ             beat accepted when req_valid[i] & req_ready[i]
//  fifo_data   out  DATA_WIDTH          to fifo data_in
//  fifo_valid  out  1                   to fifo data_in_valid
//  fifo_full   in   1                   from fifo data_in_full
//  grant_id    out  ID_W                current owner, valid while busy
//  busy        out  1                   a grant is held
// BEHAVIOUR
//  Reset (rst high at posedge): state=IDLE, busy=0, grant_id=0, beat_cnt=0, hold_cnt=0,
//   rr_ptr=NUM_REQ-1 so requester 0 wins first; req_ready=0 and fifo_valid=0 combinationally while IDLE.
//  States: IDLE, GRANT.
//  IDLE: if any req_valid, pick first set bit searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ);
//   next cycle GRANT, grant_id=pick, beat_cnt=0, hold_cnt=0. Request-to-first-beat latency: 1 cycle.
//  GRANT, g=grant_id:
//   req_ready[g]=!fifo_full; all other req_ready=0.
//   fifo_valid=req_valid[g]&!fifo_full; fifo_data=req_data[g] (don't-care when fifo_valid=0).
//   beat = fifo_valid. Never assert fifo_valid while fifo_full=1.
//   On beat: beat_cnt++, hold_cnt=0.
//   Cycle with !req_valid[g]: hold_cnt++. fifo_full alone (req_valid[g]=1) does not count.
//  Release in the cycle of: beat with req_last[g]; beat with beat_cnt==MAX_BURST-1;
//   or hold_cnt==HOLD_TIMEOUT-1 with no beat.
//   On release: rr_ptr=g. Re-arbitrate the same cycle over req_valid with g at lowest priority
//   (a beat in that cycle does not exclude g).
//   Winner found: stay GRANT with new grant_id, counters cleared, no bubble. Otherwise go IDLE.
//  Timeout or MAX_BURST release mid-burst is legal; the producer re-requests and continues later.
//   No beat is lost or duplicated.
//  fifo_full during a grant stalls without release; the grant is held indefinitely while full.
//  req_last without req_valid is ignored.
//  rst mid-burst: next cycle IDLE, no fifo_valid in the rst cycle's aftermath.
//   Beats already accepted remain in the fifo.
//  Counters saturate-free by construction: release happens before overflow.
//   Widths: beat_cnt/hold_cnt 8 bit.
// STRUCTURE
//  Package fifo_pkg: state encoding localparams (ST_IDLE=1'b0, ST_GRANT=1'b1), clog2 function,
//   NUM_REQ/width limits.
//  Sub-module rr_pick: combinational, inputs req[NUM_REQ], ptr[ID_W]; outputs found, idx[ID_W].
//   Rotate-then-priority-encode. Instantiated once, shared by IDLE and release paths.
//  Top: FSM, counters, rr_ptr, data mux.
// TESTING
//  1 Reset: rst=1 for 2 cycles with all req_valid=1 -> busy=0, fifo_valid=0, req_ready=0;
//    first grant after rst is id 0.
//  2 Round-robin: req 0,1,3 each send a 2-beat burst (last on beat 2), always valid ->
//    fifo beats in order 0,0,1,1,3,3, no idle cycle between bursts.
//  3 MAX_BURST=4, req 2 sends 10 beats with no last, req 1 also valid ->
//    4 beats of 2, then 1's burst, then 2 resumes. All 10 beats of 2 are in order.
//  4 Backpressure: fifo_full=1 for 5 cycles mid-burst ->
//    fifo_valid=0 and req_ready=0 throughout, grant unchanged, hold_cnt stays 0, no beat lost.
//  5 Timeout HOLD_TIMEOUT=8: granted req 1 drops valid after 1 beat ->
//    release after exactly 8 idle cycles, req 3 granted next cycle.
//  6 Rst asserted during beat 3 of a 6-beat burst -> exactly 3 beats written, IDLE after,
//    new arbitration starts from id 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and limits for the fifo write-port arbiter.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 16;
    localparam int LIMIT_MAX   = 255;
    localparam int CNT_W       = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping; ptr itself is lowest priority.
// Purely combinational, no backpressure.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port; 1-cycle request-to-first-beat, no bubble between grants.
// fifo_full stalls the current owner (no release); data path is a combinational mux.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int MAX_BURST    = 16,
    parameter  int HOLD_TIMEOUT = 8,
    localparam int ID_W         = clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_valid,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
        MAX_BURST < 1 || MAX_BURST > LIMIT_MAX ||
        HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > LIMIT_MAX) begin : g_bad_param
        $error("fifo_write_arbiter: parameter out of range");
    end

    state_t            state, state_n;
    logic [ID_W-1:0]   grant_n, rr_ptr, rr_n, pick_ptr, pick_idx;
    logic [CNT_W-1:0]  beat_cnt, beat_n, hold_cnt, hold_n;
    logic              pick_found, rel;

    // In IDLE search after the last owner; on release search after the current owner.
    assign pick_ptr = (state == ST_IDLE) ? rr_ptr : grant_id;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign fifo_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign busy      = (state == ST_GRANT);

    always_comb begin
        state_n    = state;
        grant_n    = grant_id;
        beat_n     = beat_cnt;
        hold_n     = hold_cnt;
        rr_n       = rr_ptr;
        req_ready  = '0;
        fifo_valid = 1'b0;
        rel        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_n = ST_GRANT;
                    grant_n = pick_idx;
                    beat_n  = '0;
                    hold_n  = '0;
                end
            end
            ST_GRANT: begin
                req_ready[grant_id] = !fifo_full;
                fifo_valid          = req_valid[grant_id] && !fifo_full;
                if (fifo_valid) begin
                    beat_n = beat_cnt + 1'b1;
                    hold_n = '0;
                    rel    = req_last[grant_id] || (beat_cnt == CNT_W'(MAX_BURST - 1));
                end else if (!req_valid[grant_id]) begin
                    hold_n = hold_cnt + 1'b1;
                    rel    = (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1));
                end
                if (rel) begin
                    rr_n   = grant_id;
                    beat_n = '0;
                    hold_n = '0;
                    if (pick_found) grant_n = pick_idx;
                    else            state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            beat_cnt <= '0;
            hold_cnt <= '0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            beat_cnt <= beat_n;
            hold_cnt <= hold_n;
            rr_ptr   <= rr_n;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: queue-driven producers, beats logged at the fifo side.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int HT = 8;

    logic                 clock;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR*DW-1:0]     req_data;
    logic [NR-1:0]        req_last;
    logic [NR-1:0]        req_ready;
    logic [DW-1:0]        fifo_data;
    logic                 fifo_valid;
    logic                 fifo_full;
    logic [1:0]           grant_id;
    logic                 busy;

    fifo_write_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] src_q[NR][$];
    logic          src_l[NR][$];
    logic [DW-1:0] log_q[$];
    int            log_cyc[$];
    int            cyc;
    int            errors;
    int            checks;
    logic          s_fv, s_busy;
    logic [NR-1:0] s_rdy;
    logic [1:0]    s_gid;

    function automatic logic [DW-1:0] mk(input int id, input int seq);
        return DW'((id << 24) | seq);
    endfunction

    task automatic load(input int id, input int n, input bit last_at_end);
        for (int k = 0; k < n; k++) begin
            src_q[id].push_back(mk(id, k));
            src_l[id].push_back(last_at_end && (k == n - 1));
        end
    endtask

    // One clock: drive from queue heads, sample settled outputs, log beats, pop accepted heads.
    task automatic step();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = (src_q[i].size() > 0);
            req_data[i*DW +: DW]  = req_valid[i] ? src_q[i][0] : '0;
            req_last[i]           = req_valid[i] ? src_l[i][0] : 1'b0;
        end
        #1;
        s_fv   = fifo_valid;
        s_rdy  = req_ready;
        s_gid  = grant_id;
        s_busy = busy;
        if (fifo_valid === 1'b1) begin
            log_q.push_back(fifo_data);
            log_cyc.push_back(cyc);
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && (req_ready[i] === 1'b1)) begin
                void'(src_q[i].pop_front());
                void'(src_l[i].pop_front());
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete();
            src_l[i].delete();
        end
        log_q.delete();
        log_cyc.delete();
        fifo_full = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) load(i, 2, 1'b1);
        rst = 1'b1;
        step();
        step();
        checks++;
        if (s_busy !== 1'b0 || s_fv !== 1'b0 || s_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b fifo_valid=%b req_ready=%b, want 0/0/0000", s_busy, s_fv, s_rdy);
        end
        rst = 1'b0;
        cyc = 0;
        step();
        checks++;
        if (s_busy !== 1'b0 || s_fv !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b fifo_valid=%b, want 0/0", s_busy, s_fv);
        end
        step();
        checks++;
        if (s_busy !== 1'b1 || s_gid !== 2'd0 || s_fv !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: busy=%b grant_id=%0d fifo_valid=%b, want 1/0/1", s_busy, s_gid, s_fv);
        end
    endtask

    task automatic test_round_robin();
        int exp_id[6]  = '{0, 0, 1, 1, 3, 3};
        int exp_seq[6] = '{0, 1, 0, 1, 0, 1};
        do_reset();
        load(0, 2, 1'b1);
        load(1, 2, 1'b1);
        load(3, 2, 1'b1);
        repeat (10) step();
        checks++;
        if (log_q.size() != 6) begin
            errors++;
            $display("FAIL rr_count: beats=%0d, want 6", log_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (log_q[k] !== mk(exp_id[k], exp_seq[k]) || log_cyc[k] != k + 1) begin
                    errors++;
                    $display("FAIL rr_beat%0d: data=%h cyc=%0d, want data=%h cyc=%0d",
                             k, log_q[k], log_cyc[k], mk(exp_id[k], exp_seq[k]), k + 1);
                end
            end
        end
    endtask

    task automatic test_max_burst();
        int exp_id[16]  = '{2, 2, 2, 2, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        int exp_seq[16] = '{0, 1, 2, 3, 0, 1, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0};
        do_reset();
        load(2, 10, 1'b0);
        step();
        load(1, 2, 1'b1);
        repeat (25) step();
        checks++;
        if (log_q.size() != 12) begin
            errors++;
            $display("FAIL maxb_count: beats=%0d, want 12", log_q.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (log_q[k] !== mk(exp_id[k], exp_seq[k]) || log_cyc[k] != k + 1) begin
                    errors++;
                    $display("FAIL maxb_beat%0d: data=%h cyc=%0d, want data=%h cyc=%0d",
                             k, log_q[k], log_cyc[k], mk(exp_id[k], exp_seq[k]), k + 1);
                end
            end
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL maxb_idle_after_timeout: busy=%b, want 0", s_busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load(0, 6, 1'b1);
        step();
        step();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (s_fv !== 1'b0 || s_rdy !== 4'b0000 || s_gid !== 2'd0 || s_busy !== 1'b1 ||
                dut.hold_cnt !== 8'd0) begin
                errors++;
                $display("FAIL bp_stall%0d: fifo_valid=%b req_ready=%b grant=%0d busy=%b hold=%0d, want 0/0000/0/1/0",
                         c, s_fv, s_rdy, s_gid, s_busy, dut.hold_cnt);
            end
        end
        fifo_full = 1'b0;
        repeat (10) step();
        checks++;
        if (log_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count: beats=%0d, want 6", log_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (log_q[k] !== mk(0, k)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: data=%h, want %h", k, log_q[k], mk(0, k));
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        load(1, 1, 1'b0);
        load(3, 1, 1'b1);
        step();
        step();
        checks++;
        if (s_fv !== 1'b1 || s_gid !== 2'd1) begin
            errors++;
            $display("FAIL to_first_beat: fifo_valid=%b grant=%0d, want 1/1", s_fv, s_gid);
        end
        for (int c = 2; c <= 9; c++) begin
            step();
            checks++;
            if (s_fv !== 1'b0 || s_gid !== 2'd1 || s_busy !== 1'b1) begin
                errors++;
                $display("FAIL to_hold_cyc%0d: fifo_valid=%b grant=%0d busy=%b, want 0/1/1", c, s_fv, s_gid, s_busy);
            end
        end
        step();
        checks++;
        if (s_fv !== 1'b1 || s_gid !== 2'd3 || log_q.size() != 2 || log_q[1] !== mk(3, 0)) begin
            errors++;
            $display("FAIL to_next_grant: fifo_valid=%b grant=%0d beats=%0d, want 1/3/2", s_fv, s_gid, log_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load(0, 6, 1'b1);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (log_q.size() != 3) begin
            errors++;
            $display("FAIL rstb_count: beats=%0d, want 3", log_q.size());
        end
        load(1, 2, 1'b1);
        step();
        checks++;
        if (s_fv !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstb_idle: fifo_valid=%b busy=%b, want 0/0", s_fv, s_busy);
        end
        step();
        checks++;
        if (s_gid !== 2'd0 || s_busy !== 1'b1 || s_fv !== 1'b1 || log_q.size() != 4 || log_q[3] !== mk(0, 3)) begin
            errors++;
            $display("FAIL rstb_rearb: grant=%0d busy=%b fifo_valid=%b beats=%0d, want 0/1/1/4",
                     s_gid, s_busy, s_fv, log_q.size());
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        @(negedge clock);
        test_reset();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_timeout();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
